data_mem_resp: RTL and testbench
================================

# data_mem_resp

Responder end of the core's data-memory request interface. It accepts the level-held `re`/`we` request, 64-bit address, byte mask and write data issued by the load/store stage, and serves them from an internal 64-bit-wide array after a programmable number of wait states. It returns the raw aligned 64-bit doubleword with a single-cycle `mem_finish`. It sits in the simulation/FPGA top beside the pipeline; the load/store stage holds its stall until `mem_finish`.

## Interface
Parameters:
- `DEPTH`, 4096: number of 64-bit words in the array (power of two).
- `BASE`, 64'h8000_0000: byte address of word 0.
- `LATENCY`, 2: wait-state cycles between acceptance and response, 0..15.

Ports:
- `clk` in 1: single clock, all state on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `re` in 1: read request, level, held until `mem_finish`.
- `we` in 1: write request, level, held until `mem_finish`.
- `data_addr_i` in 64: byte address; bits [2:0] ignored.
- `wmask_i` in 8: byte enables; bit n covers bits [8n+7:8n].
- `wdata_i` in 64: write data, already lane-aligned.
- `rdata_o` out 64: aligned read doubleword; valid only while `mem_finish`=1, else 0.
- `mem_finish` out 1: one-cycle response pulse.
- `err_o` out 1: pulses with `mem_finish` on an out-of-range or illegal request.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If `re|we`, latch the request: addr, mask, wdata, and `is_wr` = `we`.
  - Load `cnt` with `LATENCY`.
  - Go to WAIT if `LATENCY`>0, else go to RESP.
- WAIT:
  - Decrement `cnt` each cycle.
  - When `cnt`==1, go to RESP.
  - Input changes are ignored because the request is latched.
- RESP (exactly one cycle):
  - Assert `mem_finish`.
  - For a read, drive `rdata_o` = array[idx].
  - For a write, update the enabled bytes of array[idx] at the closing edge; `rdata_o`=0.
  - Go to IDLE unconditionally.
- Index: `idx` = (addr − BASE) >> 3, taken as log2(DEPTH) bits.
- Range: in range iff BASE ≤ addr < BASE + DEPTH·8, computed in 64-bit unsigned arithmetic.
- Out of range:
  - Reads return 0.
  - Writes are dropped.
  - `err_o`=1 in RESP.
  - The full latency still applies.
- `re` and `we` both high: treated as a write with `err_o`=1.
- Write with `wmask_i`=0: no array change, normal finish, no error.
- The request seen in the IDLE cycle after RESP is a new request. There is a mandatory one-cycle IDLE bubble between back-to-back accesses.
- Reset behaviour:
  - Async reset forces IDLE, `cnt`=0 and the latched request to 0.
  - Array contents are not reset.
  - A write in flight when reset asserts is not committed.

## Timing
- Reset values: `mem_finish`=0, `rdata_o`=0, `err_o`=0.
- A request first seen in cycle T gives `mem_finish` in cycle T+LATENCY+1.
- The earliest next acceptance is T+LATENCY+2, so throughput is one access per LATENCY+2 cycles.
- `rdata_o` and `err_o` are driven from registered state (latched addr, FSM); no combinational path from request inputs to outputs.
- A write is visible to a read accepted in any later cycle.
- A request dropped by the requester before `mem_finish` is still completed; the requester must hold until finish.

## Structure
- Shared package (`defines.v`):
  - FSM state encodings `DMR_IDLE`/`DMR_WAIT`/`DMR_RESP`.
  - Reuse the existing `ysyx22040228_DATAADDRBUS`, `ysyx22040228_DATABUS` and `ysyx22040228_ZEROWORD`.
- One natural sub-module, `dmem_bytewrite_ram`: a DEPTH×64 array with 8 byte-write enables, an asynchronous read port and a synchronous write port. The FSM, counter and range check stay in `data_mem_resp`.

## Test plan
- LATENCY=2 write then read:
  - `we`, addr 0x8000_0008, mask 0xFF, wdata 0x1122334455667788 -> finish at T+3, `err_o`=0.
  - Following `re` at the same addr -> `rdata_o`=0x1122334455667788 exactly 3 cycles after acceptance.
- Byte-masked write:
  - Preload 0xFFFF_FFFF_FFFF_FFFF at 0x8000_0010, then write mask 0x0C, wdata 0x0000_0000_ABCD_0000.
  - Read -> 0xFFFF_FFFF_ABCD_FFFF.
- Out of range:
  - Read 0x7FFF_FFF8 -> `rdata_o`=0, `err_o`=1 with finish.
  - Write 0x8000_0000+DEPTH·8 -> `err_o`=1; word 0 and the last word unchanged.
- LATENCY=0 back-to-back:
  - `re` held continuously across two requests -> finish pulses at T+1 and T+3, never on consecutive cycles.
- Reset mid-WAIT:
  - Assert `rst`=0 during WAIT of a write to 0x8000_0020 -> `mem_finish` stays 0, state IDLE, no write committed.
  - Re-read after reset -> old value.
- Illegal request: `re`=`we`=1 with mask 0x01 -> byte 0 written, `err_o`=1, `rdata_o`=0.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data-memory responder: bus widths and FSM state encodings.
package data_mem_resp_pkg;

  localparam int unsigned ysyx22040228_DATAADDRBUS = 64;
  localparam int unsigned ysyx22040228_DATABUS     = 64;
  localparam logic [63:0] ysyx22040228_ZEROWORD    = 64'h0;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_e;

endpackage

// File: rtl/data_mem_resp_bytewrite_ram.sv
// DEPTH x 64 storage with per-byte write enables, synchronous write and asynchronous read.
module dmem_bytewrite_ram
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic                                  clk,
  input  logic [7:0]                            be_i,
  input  logic [AW-1:0]                         addr_i,
  input  logic [ysyx22040228_DATABUS-1:0]       wdata_i,
  output logic [ysyx22040228_DATABUS-1:0]       rdata_o
);

  logic [ysyx22040228_DATABUS-1:0] mem [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (be_i[b]) begin
        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: latches a level-held request, waits LATENCY cycles, then answers with a one-cycle finish.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = 4096,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  re,
  input  logic                                  we,
  input  logic [ysyx22040228_DATAADDRBUS-1:0]   data_addr_i,
  input  logic [7:0]                            wmask_i,
  input  logic [ysyx22040228_DATABUS-1:0]       wdata_i,
  output logic [ysyx22040228_DATABUS-1:0]       rdata_o,
  output logic                                  mem_finish,
  output logic                                  err_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  dmr_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  mask_q, mask_d;
  logic [63:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic        both_q, both_d;

  logic [63:0] off;
  logic        in_range;
  logic        resp;
  logic [7:0]  ram_be;
  logic [63:0] ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    both_d  = both_q;
    unique case (state_q)
      DMR_IDLE: begin
        if (re | we) begin
          addr_d  = data_addr_i;
          mask_d  = wmask_i;
          wdata_d = wdata_i;
          is_wr_d = we;
          both_d  = re & we;
          cnt_d   = LAT;
          state_d = (LAT != 4'd0) ? DMR_WAIT : DMR_RESP;
        end
      end
      DMR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DMR_RESP;
        end
      end
      DMR_RESP: state_d = DMR_IDLE;
      default:  state_d = DMR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DMR_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 64'd0;
      mask_q  <= 8'd0;
      wdata_q <= 64'd0;
      is_wr_q <= 1'b0;
      both_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      both_q  <= both_d;
    end
  end

  // Offset comparison avoids overflow of BASE + SPAN near the top of the address space.
  assign off      = addr_q - BASE;
  assign in_range = (addr_q >= BASE) && (off < SPAN);
  assign resp     = (state_q == DMR_RESP);
  assign ram_be   = (resp && is_wr_q && in_range) ? mask_q : 8'h00;

  dmem_bytewrite_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .be_i    (ram_be),
    .addr_i  (off[AW+2:3]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign mem_finish = resp;
  assign err_o      = resp && (!in_range || both_q);
  assign rdata_o    = (resp && !is_wr_q && in_range) ? ram_rdata : ysyx22040228_ZEROWORD;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench: table of accesses on a LATENCY=2 instance, plus reset and LATENCY=0 sequences.
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        re, we;
  logic [63:0] addr;
  logic [7:0]  mask;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        fin, err;

  logic        re0, we0;
  logic [63:0] addr0;
  logic [7:0]  mask0;
  logic [63:0] wdata0;
  logic [63:0] rdata0;
  logic        fin0, err0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        re;
    logic        we;
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb_e;
  vec_t vecs[18];

  data_mem_resp #(.DEPTH(4096), .BASE(64'h8000_0000), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .data_addr_i(addr), .wmask_i(mask),
    .wdata_i(wdata), .rdata_o(rdata), .mem_finish(fin), .err_o(err)
  );

  data_mem_resp #(.DEPTH(64), .BASE(64'h8000_0000), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .re(re0), .we(we0), .data_addr_i(addr0), .wmask_i(mask0),
    .wdata_i(wdata0), .rdata_o(rdata0), .mem_finish(fin0), .err_o(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard: every finish of the LATENCY=2 instance consumes one expectation.
  always @(negedge clk) begin
    if (fin === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_finish rdata=%h err=%b", rdata, err);
      end else begin
        sb_e = sb_q.pop_front();
        if (rdata !== sb_e.rdata || err !== sb_e.err) begin
          errors++;
          $display("[TB] FAIL response got rdata=%h err=%b want rdata=%h err=%b",
                   rdata, err, sb_e.rdata, sb_e.err);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int id);
    int  k;
    bit  seen;
    @(negedge clk);
    re    = v.re;
    we    = v.we;
    addr  = v.addr;
    mask  = v.mask;
    wdata = v.wdata;
    sb_q.push_back({v.exp_rdata, v.exp_err});
    seen = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (fin === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    re = 1'b0;
    we = 1'b0;
    if (!seen) begin
      void'(sb_q.pop_back());
      k = -1;
    end
    checkOutput($sformatf("latency_vec%0d", id), 64'(k), 64'(LAT + 1));
  endtask

  initial begin
    rst = 1'b0;
    re = 0; we = 0; addr = 0; mask = 0; wdata = 0;
    re0 = 0; we0 = 0; addr0 = 0; mask0 = 0; wdata0 = 0;

    vecs[0]  = '{1'b0, 1'b1, 64'h8000_0008, 8'hFF, 64'h1122334455667788, 64'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 64'h8000_0008, 8'h00, 64'h0, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 64'h8000_0010, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 64'h8000_0010, 8'h0C, 64'h0000_0000_ABCD_0000, 64'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 64'hFFFF_FFFF_ABCD_FFFF, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 64'h8000_0000, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 64'h8000_7FF8, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 64'h7FFF_FFF8, 8'h00, 64'h0, 64'h0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 64'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 64'h8000_0000, 8'h00, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 64'h8000_7FF8, 8'h00, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 64'h8000_0008, 8'h00, 64'h0, 64'h0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 64'h8000_000D, 8'h00, 64'h0, 64'h1122334455667788, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 64'h8000_0018, 8'hFF, 64'h1111_1111_1111_1111, 64'h0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 64'h8000_0018, 8'h01, 64'h0000_0000_0000_00CC, 64'h0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 64'h8000_0018, 8'h00, 64'h0, 64'h1111_1111_1111_11CC, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 8'h00, 64'h0, 64'h0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 64'h8000_0020, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("reset_finish", 64'(fin), 64'd0);
    checkOutput("reset_rdata", rdata, 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_finish0", 64'(fin0), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset lands while a write to 0x8000_0020 is waiting; it must never commit.
    @(negedge clk);
    we = 1'b1; addr = 64'h8000_0020; mask = 8'hFF; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    checkOutput("midwait_state", 64'(u_dut.state_q), 64'(DMR_WAIT));
    rst = 1'b0;
    we  = 1'b0;
    #1;
    checkOutput("rst_state", 64'(u_dut.state_q), 64'(DMR_IDLE));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_finish_%0d", i), 64'(fin), 64'd0);
    end
    rst = 1'b1;
    applyStimulus('{1'b1, 1'b0, 64'h8000_0020, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0}, 100);

    // LATENCY=0 instance: preload, then hold re across two requests.
    @(negedge clk);
    we0 = 1'b1; addr0 = 64'h8000_0040; mask0 = 8'hFF; wdata0 = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    checkOutput("l0_write_finish", 64'(fin0), 64'd1);
    checkOutput("l0_write_err", 64'(err0), 64'd0);
    we0 = 1'b0;
    @(negedge clk);
    re0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("l0_finish_%0d", i), 64'(fin0), 64'(i % 2));
      checkOutput($sformatf("l0_rdata_%0d", i), rdata0, (i % 2 == 1) ? 64'hCAFE_F00D_1234_5678 : 64'h0);
    end
    re0 = 1'b0;
    addr0 = 64'h8000_0200;
    @(negedge clk);
    re0 = 1'b1;
    @(negedge clk);
    checkOutput("l0_oor_finish", 64'(fin0), 64'd1);
    checkOutput("l0_oor_err", 64'(err0), 64'd1);
    checkOutput("l0_oor_rdata", rdata0, 64'd0);
    re0 = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
